// File: rtl/led_digit_sequencer_if.sv
// Digit inputs and LED outputs of led_digit_sequencer.
interface led_digit_sequencer_if;
   logic [4:0] i_100;
   logic [4:0] i_010;
   logic [4:0] i_001;
   logic       i_hold;
   logic [7:0] o_LED;
   logic       o_frame;
   logic       o_err;

   modport master (
      output i_100, i_010, i_001, i_hold,
      input  o_LED, o_frame, o_err
   );

   modport slave (
      input  i_100, i_010, i_001, i_hold,
      output o_LED, o_frame, o_err
   );
endinterface

// File: rtl/led_digit_sequencer.sv
// Time-multiplexes a snapshotted 3-digit Johnson-coded reading onto one 7-seg+DP byte.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module led_digit_sequencer #(
   parameter int unsigned pDWELL = 1000,
   parameter int unsigned pBLANK = 250
) (
   input logic                  i_clk,
   input logic                  i_rst,
   led_digit_sequencer_if.slave bus
);

   localparam int unsigned CNT_MAX = (pDWELL > pBLANK) ? pDWELL : pBLANK;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam bit          HAS_GAP = (pBLANK != 0);

   localparam logic [CW-1:0] LD_DWELL = CW'(pDWELL);
   localparam logic [CW-1:0] LD_BLANK = CW'(pBLANK);
   localparam logic [CW-1:0] LD_ONE   = CW'(1);

   localparam logic [7:0] LED_OFF = 8'h00;
   localparam logic [7:0] LED_SEP = 8'h80;

   typedef enum logic [2:0] {
      ST_SNAP, ST_D100, ST_GAP1, ST_D010, ST_GAP2, ST_D001, ST_GAP3, ST_SEP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    s100_q, s010_q, s001_q;
   logic [4:0]    n100, n010, n001;
   logic [7:0]    led_q, led_d;
   logic          frame_q, frame_d;
   logic          err_q, err_d;
   logic          capture;
   logic          leave;
   logic [4:0]    d100, d010, d001;
   logic          blank100, blank010;
   logic [7:0]    seg100, seg010, seg001;

   // {valid, value}; invalid codes return valid=0
   function automatic logic [4:0] jdec(input logic [4:0] c);
      case (c)
         5'b00000: return {1'b1, 4'd0};
         5'b00001: return {1'b1, 4'd1};
         5'b00011: return {1'b1, 4'd2};
         5'b00111: return {1'b1, 4'd3};
         5'b01111: return {1'b1, 4'd4};
         5'b11111: return {1'b1, 4'd5};
         5'b11110: return {1'b1, 4'd6};
         5'b11100: return {1'b1, 4'd7};
         5'b11000: return {1'b1, 4'd8};
         5'b10000: return {1'b1, 4'd9};
         default:  return {1'b0, 4'd0};
      endcase
   endfunction

   function automatic logic [6:0] seg(input logic [4:0] d);
      if (!d[4]) return 7'h79;
      case (d[3:0])
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   // Snapshot as it will be after this edge; digit patterns come from it
   assign capture = (state_q == ST_SNAP) && (cnt_q == LD_ONE) && !bus.i_hold;
   assign n100    = capture ? bus.i_100 : s100_q;
   assign n010    = capture ? bus.i_010 : s010_q;
   assign n001    = capture ? bus.i_001 : s001_q;

   assign d100 = jdec(n100);
   assign d010 = jdec(n010);
   assign d001 = jdec(n001);

`ifdef LEADING_ZERO_BLANK_EN
   assign blank100 = (d100 == {1'b1, 4'd0});
   assign blank010 = blank100 && (d010 == {1'b1, 4'd0});
`else
   assign blank100 = 1'b0;
   assign blank010 = 1'b0;
`endif

   assign seg100 = blank100 ? LED_OFF : {1'b0, seg(d100)};
   assign seg010 = blank010 ? LED_OFF : {1'b0, seg(d010)};
   assign seg001 = {1'b0, seg(d001)};

   assign leave = (cnt_q == LD_ONE);

   // Next state, counter reload and registered-output values on state entry
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q - LD_ONE;
      led_d   = led_q;
      frame_d = 1'b0;
      err_d   = err_q;
      case (state_q)
         ST_SNAP: begin
            if (cnt_q == '0) begin
               // first cycle out of reset: enter SNAP proper
               cnt_d   = LD_ONE;
               led_d   = LED_OFF;
               frame_d = 1'b1;
            end else if (leave) begin
               state_d = ST_D100;
               cnt_d   = LD_DWELL;
               led_d   = seg100;
               err_d   = !(d100[4] && d010[4] && d001[4]);
            end
         end
         ST_D100: begin
            if (leave) begin
               if (HAS_GAP) begin
                  state_d = ST_GAP1;
                  cnt_d   = LD_BLANK;
                  led_d   = LED_OFF;
               end else begin
                  state_d = ST_D010;
                  cnt_d   = LD_DWELL;
                  led_d   = seg010;
               end
            end
         end
         ST_GAP1: begin
            if (leave) begin
               state_d = ST_D010;
               cnt_d   = LD_DWELL;
               led_d   = seg010;
            end
         end
         ST_D010: begin
            if (leave) begin
               if (HAS_GAP) begin
                  state_d = ST_GAP2;
                  cnt_d   = LD_BLANK;
                  led_d   = LED_OFF;
               end else begin
                  state_d = ST_D001;
                  cnt_d   = LD_DWELL;
                  led_d   = seg001;
               end
            end
         end
         ST_GAP2: begin
            if (leave) begin
               state_d = ST_D001;
               cnt_d   = LD_DWELL;
               led_d   = seg001;
            end
         end
         ST_D001: begin
            if (leave) begin
               if (HAS_GAP) begin
                  state_d = ST_GAP3;
                  cnt_d   = LD_BLANK;
                  led_d   = LED_OFF;
               end else begin
                  state_d = ST_SEP;
                  cnt_d   = LD_DWELL;
                  led_d   = LED_SEP;
               end
            end
         end
         ST_GAP3: begin
            if (leave) begin
               state_d = ST_SEP;
               cnt_d   = LD_DWELL;
               led_d   = LED_SEP;
            end
         end
         ST_SEP: begin
            if (leave) begin
               state_d = ST_SNAP;
               cnt_d   = LD_ONE;
               led_d   = LED_OFF;
               frame_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_SNAP;
            cnt_d   = '0;
            led_d   = LED_OFF;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_SNAP;
         cnt_q   <= '0;
         s100_q  <= '0;
         s010_q  <= '0;
         s001_q  <= '0;
         led_q   <= LED_OFF;
         frame_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         s100_q  <= n100;
         s010_q  <= n010;
         s001_q  <= n001;
         led_q   <= led_d;
         frame_q <= frame_d;
         err_q   <= err_d;
      end
   end

   assign bus.o_LED   = led_q;
   assign bus.o_frame = frame_q;
   assign bus.o_err   = err_q;

endmodule
